// File: rtl/deca_sysid_pkg.sv
// ---------------------------------------------------------------------------
// deca_sysid_pkg: shared constants for the system-ID access controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package deca_sysid_pkg;

  localparam int LAT_CNT_W = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_RESP    = 3'd2;
  localparam logic [2:0] ST_BOOT_ID = 3'd3;
  localparam logic [2:0] ST_BOOT_TS = 3'd4;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

`default_nettype wire

// File: rtl/deca_rr_arb2.sv
// ---------------------------------------------------------------------------
// deca_rr_arb2: two-way round-robin grant; last winner loses the next tie. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module deca_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant_valid,
  output logic       grant_id
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_valid = |req;
    if (&req) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = req[1];
    end
    last_grant_d = accept ? grant_id : last_grant_q;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/deca_sysid_access_ctrl.sv
// ---------------------------------------------------------------------------
// deca_sysid_access_ctrl: shares the sysid slave between two read masters;
// optional post-reset ID/timestamp self-check under SYSID_BOOT_CHECK_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module deca_sysid_access_ctrl
  import deca_sysid_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] EXPECTED_ID  = 32'h0,
  parameter logic [31:0] EXPECTED_TS  = 32'h55375A02
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m0_read,
  input  logic        m0_address,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic        m1_read,
  input  logic        m1_address,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        boot_done,
  output logic        id_ok
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LATENCY);
`ifdef SYSID_BOOT_CHECK_EN
  localparam logic [2:0] ST_RESET = ST_BOOT_ID;
`else
  localparam logic [2:0] ST_RESET = ST_IDLE;
`endif

  logic [2:0]           state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 addr_q, addr_d;
  logic                 gnt_q, gnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 boot_done_q, boot_done_d;
  logic                 id_ok_q, id_ok_d;
`ifdef SYSID_BOOT_CHECK_EN
  logic                 boot_q, boot_d;
  logic                 match_q, match_d;
  logic                 boot_pend_q, boot_pend_d;
`endif

  logic arb_valid;
  logic arb_id;
  logic accept;

  assign accept = (state_q == ST_IDLE) && arb_valid;

  deca_rr_arb2 u_arb (
    .clk         (clock),
    .rst_n       (reset_n),
    .req         ({m1_read, m0_read}),
    .accept      (accept),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    gnt_d   = gnt_q;
    rdata_d = rdata_q;
`ifdef SYSID_BOOT_CHECK_EN
    boot_d      = boot_q;
    match_d     = match_q;
    boot_pend_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_LOAD;
          gnt_d   = arb_id;
          addr_d  = arb_id ? m1_address : m0_address;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_CNT_W'(1)) begin
`ifdef SYSID_BOOT_CHECK_EN
          // Boot reads are checked here and never reach the response path.
          if (boot_q) begin
            if (addr_q == SYSID_ADDR_ID) begin
              match_d = (sysid_readdata == EXPECTED_ID);
              state_d = ST_BOOT_TS;
            end else begin
              match_d     = match_q && (sysid_readdata == EXPECTED_TS);
              boot_pend_d = 1'b1;
              boot_d      = 1'b0;
              state_d     = ST_IDLE;
            end
          end else
`endif
          begin
            rdata_d = sysid_readdata;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
`ifdef SYSID_BOOT_CHECK_EN
      ST_BOOT_ID: begin
        addr_d  = SYSID_ADDR_ID;
        cnt_d   = LAT_LOAD;
        state_d = ST_WAIT;
      end
      ST_BOOT_TS: begin
        addr_d  = SYSID_ADDR_TS;
        cnt_d   = LAT_LOAD;
        state_d = ST_WAIT;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef SYSID_BOOT_CHECK_EN
    boot_done_d = boot_done_q | boot_pend_q;
    id_ok_d     = boot_pend_q ? match_q : id_ok_q;
`else
    boot_done_d = 1'b1;
    id_ok_d     = 1'b1;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      addr_q      <= 1'b0;
      gnt_q       <= 1'b0;
      rdata_q     <= '0;
      boot_done_q <= 1'b0;
      id_ok_q     <= 1'b0;
`ifdef SYSID_BOOT_CHECK_EN
      boot_q      <= 1'b1;
      match_q     <= 1'b0;
      boot_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      gnt_q       <= gnt_d;
      rdata_q     <= rdata_d;
      boot_done_q <= boot_done_d;
      id_ok_q     <= id_ok_d;
`ifdef SYSID_BOOT_CHECK_EN
      boot_q      <= boot_d;
      match_q     <= match_d;
      boot_pend_q <= boot_pend_d;
`endif
    end
  end

  // reset_n gates the grant so a request held through reset is never acknowledged.
  assign m0_waitrequest   = !(accept && !arb_id && reset_n);
  assign m1_waitrequest   = !(accept &&  arb_id && reset_n);
  assign m0_readdatavalid = (state_q == ST_RESP) && !gnt_q;
  assign m1_readdatavalid = (state_q == ST_RESP) &&  gnt_q;
  assign m0_readdata      = rdata_q;
  assign m1_readdata      = rdata_q;
  assign sysid_address    = addr_q;
  assign boot_done        = boot_done_q;
  assign id_ok            = id_ok_q;

endmodule

`default_nettype wire
